// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline constants (control-word layout, bubble value)
package riscv_pipe_pkg;
    localparam int CTRL_W_DEF = 16;
    localparam int CTRL_MEMRD = 0;
    localparam int CTRL_MEMWR = 1;
    localparam int CTRL_REGWR = 2;
    localparam int CTRL_BRANCH = 3;
    localparam int CTRL_JUMP = 4;
    localparam int CTRL_ALUSRC = 5;
    localparam int MEMRD_BIT_DEF = CTRL_MEMRD;
    // A bubble carries an all-zero control word so it has no side effects downstream.
    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_bypass.sv
// id_ex_bypass: two-operand writeback forwarding compare and mux
// Ports: wb_we/wb_rd/wb_wdata writeback port; rs1/rs2 source indices;
//        d1/d2 default operands; q1/q2 selected operands. x0 is never forwarded.
module id_ex_bypass
    import riscv_pipe_pkg::*;
(
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_wdata,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    output logic [31:0] q1,
    output logic [31:0] q2
);
    always_comb begin
        q1 = (wb_we && wb_rd != 5'd0 && wb_rd == rs1) ? wb_wdata : d1;
        q2 = (wb_we && wb_rd != 5'd0 && wb_rd == rs2) ? wb_wdata : d2;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall, flush and load-use bubble insertion
// Ports: clk, rst (sync active-high); stall/flush control; id_* decode inputs;
//        wb_* writeback port; load_use (combinational hazard); ex_* registered outputs.
// Macro ID_EX_BYPASS_EN: adds writeback-to-decode bypass and stalled-operand refresh;
//        when undefined the wb_* ports are ignored.
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int MEMRD_BIT = MEMRD_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       id_rdata1,
    input  logic [31:0]       id_rdata2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_wdata,
    output logic              load_use,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_imm,
    output logic [31:0]       ex_op1,
    output logic [31:0]       ex_op2,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl
);
    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d, imm_q, imm_d, op1_q, op1_d, op2_q, op2_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       byp1, byp2, ref1, ref2;

`ifdef ID_EX_BYPASS_EN
    id_ex_bypass u_id_byp (
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .rs1(id_rs1), .rs2(id_rs2), .d1(id_rdata1), .d2(id_rdata2),
        .q1(byp1), .q2(byp2)
    );
    // Held operands only pick up writebacks while a real instruction sits here.
    id_ex_bypass u_ex_byp (
        .wb_we(wb_we && valid_q), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .rs1(rs1_q), .rs2(rs2_q), .d1(op1_q), .d2(op2_q),
        .q1(ref1), .q2(ref2)
    );
`else
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_rd, wb_wdata};
    assign byp1 = id_rdata1;
    assign byp2 = id_rdata2;
    assign ref1 = op1_q;
    assign ref2 = op2_q;
`endif

    assign load_use = valid_q && ctrl_q[MEMRD_BIT] && rd_q != 5'd0 && id_valid &&
                      (rd_q == id_rs1 || rd_q == id_rs2);

    always_comb begin
        valid_d = valid_q;
        pc_d = pc_q;
        imm_d = imm_q;
        op1_d = op1_q;
        op2_d = op2_q;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        rd_d = rd_q;
        ctrl_d = ctrl_q;
        // Stall outranks load_use; flush outranks both.
        if (flush || (!stall && load_use)) begin
            valid_d = 1'b0;
            ctrl_d = CTRL_W'(CTRL_BUBBLE);
        end else if (stall) begin
            op1_d = ref1;
            op2_d = ref2;
        end else begin
            valid_d = id_valid;
            pc_d = id_pc;
            imm_d = id_imm;
            op1_d = byp1;
            op2_d = byp2;
            rs1_d = id_rs1;
            rs2_d = id_rs2;
            rd_d = id_rd;
            ctrl_d = id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q <= '0;
            imm_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q <= '0;
            ctrl_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q <= pc_d;
            imm_q <= imm_d;
            op1_q <= op1_d;
            op2_q <= op2_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            rd_q <= rd_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign ex_valid = valid_q;
    assign ex_pc = pc_q;
    assign ex_imm = imm_q;
    assign ex_op1 = op1_q;
    assign ex_op2 = op2_q;
    assign ex_rs1 = rs1_q;
    assign ex_rs2 = rs2_q;
    assign ex_rd = rd_q;
    assign ex_ctrl = ctrl_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage (directed hazards plus random traffic)
module tb_id_ex_stage;
`ifdef ID_EX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [15:0] ctrl;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid, wb_we, load_use;
    logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm, wb_wdata;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [15:0] id_ctrl;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [15:0] ex_ctrl;

    int   n_tests = 0;
    int   n_fail = 0;
    ex_t  m = '0;
    bit   known = 1'b0;
    ex_t  sb[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .load_use(load_use),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
    );

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] d);
        return (BYP && wb_we && wb_rd != 5'd0 && wb_rd == rs) ? wb_wdata : d;
    endfunction

    function automatic logic model_lu();
        return m.v && m.ctrl[0] && m.rd != 5'd0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    // Inputs are set after a falling edge; this checks load_use, pushes the
    // expected next state, then compares it just after the rising edge.
    task automatic step(input string tag);
        ex_t e;
        ex_t got;
        #1;
        if (known) chk({tag, ".load_use"}, 160'(load_use), 160'(model_lu()));
        e = m;
        if (rst) e = '0;
        else if (flush || (!stall && model_lu())) begin
            e.v = 1'b0;
            e.ctrl = '0;
        end else if (stall) begin
            if (m.v) begin
                e.op1 = fwd(m.rs1, m.op1);
                e.op2 = fwd(m.rs2, m.op2);
            end
        end else
            e = '{id_valid, id_pc, id_imm, fwd(id_rs1, id_rdata1), fwd(id_rs2, id_rdata2),
                  id_rs1, id_rs2, id_rd, id_ctrl};
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = {ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs1, ex_rs2, ex_rd, ex_ctrl};
        e = sb.pop_front();
        if (rst) known = 1'b1;
        chk(tag, got, e);
        m = e;
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; stall = 0; flush = 0; wb_we = 0; wb_rd = 0; wb_wdata = 0;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [15:0] ctrl);
        id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rdata1 = d1; id_rdata2 = d2; id_imm = pc ^ 32'h0F0F; id_ctrl = ctrl;
    endtask

    initial begin
        @(negedge clk);
        idle();
        rst = 1;
        instr(32'h100, 5'd3, 5'd4, 5'd7, 32'hDEAD, 32'hBEEF, 16'h0005);
        wb_we = 1; wb_rd = 5'd3; wb_wdata = 32'h1234;
        step("reset1");
        step("reset2");
        chk("reset_ex_valid", 160'(ex_valid), 160'd0);
        chk("reset_load_use", 160'(load_use), 160'd0);

        idle();
        instr(32'h200, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 16'h0004);
        wb_we = 1; wb_rd = 5'd5; wb_wdata = 32'hABCD;
        step("bypass");
        chk("bypass_op1", 160'(ex_op1), BYP ? 160'hABCD : 160'h11);
        wb_rd = 5'd0;
        step("bypass_x0");
        chk("bypass_x0_op1", 160'(ex_op1), 160'h11);

        idle();
        instr(32'h300, 5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 16'h0001);
        step("load");
        instr(32'h304, 5'd9, 5'd7, 5'd10, 32'h33, 32'h44, 16'h0004);
        step("load_use_bubble");
        chk("bubble_valid", 160'(ex_valid), 160'd0);
        chk("bubble_ctrl", 160'(ex_ctrl), 160'd0);
        #1 chk("lu_cleared", 160'(load_use), 160'd0);
        step("load_use_release");
        chk("release_pc", 160'(ex_pc), 160'h304);

        instr(32'h400, 5'd9, 5'd3, 5'd11, 32'h1, 32'h2, 16'h0004);
        step("pre_stall");
        stall = 1;
        instr(32'h404, 5'd12, 5'd13, 5'd14, 32'h77, 32'h88, 16'h0010);
        step("stall1");
        wb_we = 1; wb_rd = 5'd9; wb_wdata = 32'h55;
        step("stall2_refresh");
        chk("refresh_op1", 160'(ex_op1), BYP ? 160'h55 : 160'h1);
        chk("refresh_pc", 160'(ex_pc), 160'h400);
        wb_rd = 5'd0; wb_wdata = 32'h99;
        step("stall3_x0");

        flush = 1;
        step("flush_stall");
        chk("flush_valid", 160'(ex_valid), 160'd0);
        chk("flush_ctrl", 160'(ex_ctrl), 160'd0);

        idle();
        instr(32'h500, 5'd1, 5'd2, 5'd6, 32'h5, 32'h6, 16'h0001);
        step("load2");
        instr(32'h504, 5'd6, 5'd0, 5'd8, 32'h5, 32'h6, 16'h0004);
        stall = 1;
        step("stall_over_lu");
        chk("stall_over_lu_valid", 160'(ex_valid), 160'd1);
        stall = 0; flush = 1;
        step("flush_over_lu");
        chk("flush_over_lu_valid", 160'(ex_valid), 160'd0);

        idle();
        instr(32'h600, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 16'h0004);
        step("pre_rst_stall");
        stall = 1; rst = 1;
        step("rst_during_stall");
        chk("rst_stall_pc", 160'(ex_pc), 160'd0);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 3) == 0);
            id_valid = 1'($urandom);
            id_pc = $urandom; id_imm = $urandom;
            id_rdata1 = $urandom; id_rdata2 = $urandom;
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_ctrl = 16'($urandom);
            wb_we = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 7));
            wb_wdata = $urandom;
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
